// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state geometry and ShiftRows byte-index helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package aes_pkg;

  localparam int AES_NB          = 4;
  localparam int AES_BLOCK_BYTES = 4 * AES_NB;

  // Index of the final byte of a block (row 3, column 3).
  localparam logic [3:0] AES_LAST_IDX = 4'(AES_BLOCK_BYTES - 1);

  // Direction a buffered block is emitted in.
  typedef enum logic {
    SR_FWD = 1'b0,
    SR_INV = 1'b1
  } sr_mode_e;

  // Forward ShiftRows: output byte k = r + 4c is source byte r + 4*((c + r) mod 4).
  // Column-major index means k[1:0] is the row and k[3:2] the column, so the
  // mod-4 wrap falls out of 2-bit arithmetic.
  function automatic logic [3:0] fwd_src_idx(input logic [3:0] k);
    logic [1:0] row;
    logic [1:0] col;
    row = k[1:0];
    col = k[3:2] + row;
    return {col, row};
  endfunction

  // Inverse ShiftRows: output byte k = r + 4c is source byte r + 4*((c - r) mod 4).
  function automatic logic [3:0] inv_src_idx(input logic [3:0] k);
    logic [1:0] row;
    logic [1:0] col;
    row = k[1:0];
    col = k[3:2] - row;
    return {col, row};
  endfunction

endpackage

// File: rtl/sr_block_buf.sv
// sr_block_buf: one 16-byte AES state buffer with full flag and stored ShiftRows direction.
// Latency: a write lands on the next clock; the read port is combinational from storage.
// Backpressure: none internally; the owner writes only while not full and releases after the last read.
module sr_block_buf
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic       wr_mode,
  input  logic       rel,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       mode
);

  logic [7:0] mem [AES_BLOCK_BYTES];
  sr_mode_e   mode_q;

  // Byte storage: left unreset, every byte of a block is rewritten before the block can be read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Full flag set by the last byte written, cleared on release; direction latched with byte 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      mode_q <= SR_FWD;
    end else begin
      if (wr_en && (wr_idx == AES_LAST_IDX)) begin
        full <= 1'b1;
      end else if (rel) begin
        full <= 1'b0;
      end
      if (wr_en && (wr_idx == 4'd0)) begin
        mode_q <= wr_mode ? SR_INV : SR_FWD;
      end
    end
  end

  assign rd_data = mem[rd_idx];
  assign mode    = (mode_q == SR_INV);

endmodule

// File: rtl/shift_rows_stream.sv
// shift_rows_stream: byte-serial AES ShiftRows over NUM_BUF (1 or 2) 16-byte block buffers.
// Latency: first output byte valid the cycle after a block's 16th byte is accepted; 1 byte/cycle with NUM_BUF=2.
// Backpressure: in_ready is registered (low while the write buffer is full); output held while out_ready is low.
// Build option: define SHIFT_ROWS_INV_EN to add the mode_inv port (per-block InvShiftRows select).
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter int NUM_BUF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef SHIFT_ROWS_INV_EN
  input  logic       mode_inv,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  // Pointer width and a power-of-two readback array so NUM_BUF=1 still has a legal 1-bit select.
  localparam int             PW       = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int             NBP      = 1 << PW;
  localparam logic [PW-1:0]  LAST_BUF = PW'(NUM_BUF - 1);

  if ((NUM_BUF < 1) || (NUM_BUF > 2)) begin : g_bad_num_buf
    $error("shift_rows_stream: NUM_BUF must be 1 or 2");
  end

  logic            run_q;
  logic [PW-1:0]   wr_buf;
  logic [PW-1:0]   rd_buf;
  logic [3:0]      wr_idx;
  logic [3:0]      rd_idx;
  logic [NBP-1:0]  buf_full;
  logic [NBP-1:0]  buf_mode;
  logic [7:0]      buf_rdata [NBP];
  logic            in_fire;
  logic            out_fire;
  logic            wr_mode;
  logic [3:0]      src_idx;

`ifdef SHIFT_ROWS_INV_EN
  assign wr_mode = mode_inv;
`else
  assign wr_mode = 1'b0;
`endif

  // Held low through reset so in_ready stays low until the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // in_ready depends only on flops; a buffer freed this cycle shows up next cycle.
  assign in_ready  = run_q & ~buf_full[wr_buf];
  assign in_fire   = in_valid & in_ready;

  // Blocks drain strictly in order, so the read pointer trails the write pointer.
  assign out_valid = buf_full[rd_buf];
  assign out_fire  = out_valid & out_ready;

  // Write side: byte index within the block and which buffer is being filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= 4'd0;
      wr_buf <= '0;
    end else if (in_fire) begin
      if (wr_idx == AES_LAST_IDX) begin
        wr_idx <= 4'd0;
        wr_buf <= (wr_buf == LAST_BUF) ? '0 : wr_buf + 1'b1;
      end else begin
        wr_idx <= wr_idx + 4'd1;
      end
    end
  end

  // Read side: output byte index and which buffer is being emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx <= 4'd0;
      rd_buf <= '0;
    end else if (out_fire) begin
      if (rd_idx == AES_LAST_IDX) begin
        rd_idx <= 4'd0;
        rd_buf <= (rd_buf == LAST_BUF) ? '0 : rd_buf + 1'b1;
      end else begin
        rd_idx <= rd_idx + 4'd1;
      end
    end
  end

  // Map the output position to the stored byte according to the block's latched direction.
  always_comb begin
    src_idx = fwd_src_idx(rd_idx);
    if (buf_mode[rd_buf]) begin
      src_idx = inv_src_idx(rd_idx);
    end
  end

  for (genvar gi = 0; gi < NBP; gi++) begin : g_buf
    if (gi < NUM_BUF) begin : g_inst
      logic wr_en;
      logic rel;

      assign wr_en = in_fire && (wr_buf == PW'(gi));
      assign rel   = out_fire && (rd_buf == PW'(gi)) && (rd_idx == AES_LAST_IDX);

      sr_block_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (in_data),
        .wr_mode (wr_mode),
        .rel     (rel),
        .rd_idx  (src_idx),
        .rd_data (buf_rdata[gi]),
        .full    (buf_full[gi]),
        .mode    (buf_mode[gi])
      );
    end else begin : g_pad
      // Unpopulated slot of the power-of-two array: never full, never selected.
      assign buf_full[gi]  = 1'b0;
      assign buf_mode[gi]  = 1'b0;
      assign buf_rdata[gi] = 8'h00;
    end
  end

  // Output mux is forced to zero whenever nothing is valid, which covers reset.
  assign out_data = out_valid ? buf_rdata[rd_buf] : 8'h00;
  assign out_last = out_valid && (rd_idx == AES_LAST_IDX);

endmodule

// File: tb/tb_shift_rows_stream.sv
// tb_shift_rows_stream: directed table-driven checks for shift_rows_stream (NUM_BUF=2 and NUM_BUF=1).
// Inputs change and outputs are sampled on the falling edge; transfers happen on the rising edge.
// Build option: define SHIFT_ROWS_INV_EN to include the inverse-mode block.
module tb_shift_rows_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
`ifdef SHIFT_ROWS_INV_EN
  logic       mode_inv;
`endif

  logic       in_ready2, out_valid2, out_last2;
  logic [7:0] out_data2;
  logic       in_ready1, out_valid1, out_last1;
  logic [7:0] out_data1;

  always #5 clk = ~clk;

  shift_rows_stream #(.NUM_BUF(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SHIFT_ROWS_INV_EN
    .mode_inv  (mode_inv),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_data   (in_data),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_data  (out_data2),
    .out_last  (out_last2)
  );

  shift_rows_stream #(.NUM_BUF(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SHIFT_ROWS_INV_EN
    .mode_inv  (mode_inv),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .out_last  (out_last1)
  );

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
    logic       exp_last;
  } vec_t;

  logic [7:0] fwd_tab [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                               8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
`ifdef SHIFT_ROWS_INV_EN
  logic [7:0] inv_tab [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                               8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
`endif

  vec_t tbl [16];

  int nvec;
  int nmis;
  int cyc;
  int acc2;
  int acc2_cyc;
  int acc1;
  int acc1_16;
  int l1_cyc;
  int hold_bad;
  int low_cnt;
  logic [7:0] oq2 [$];
  logic       lq2 [$];
  int         cq2 [$];
  logic       rdy1_hist [0:4095];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Record what transfers at the coming rising edge, then advance one cycle.
  task automatic step();
    if (rst_n) begin
      if (in_valid && in_ready2) begin
        acc2++;
        acc2_cyc = cyc;
      end
      if (out_valid2 && out_ready) begin
        oq2.push_back(out_data2);
        lq2.push_back(out_last2);
        cq2.push_back(cyc);
      end
      if (in_valid && in_ready1) begin
        acc1++;
        if (acc1 == 16) acc1_16 = cyc;
      end
      if (out_valid1 && out_ready && out_last1) l1_cyc = cyc;
      if (cyc < 4096) rdy1_hist[cyc] = in_ready1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear();
    oq2.delete();
    lq2.delete();
    cq2.delete();
    acc2 = 0;
    acc2_cyc = -100;
    acc1 = 0;
    acc1_16 = -100;
    l1_cyc = -100;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    rst_n     = 1'b1;
    step();
    clear();
  endtask

  task automatic drain(input int n);
    int b;
    b = 0;
    in_valid = 1'b0;
    while ((oq2.size() < n) && (b < 200)) begin
      step();
      b++;
    end
    chk("drain_count", oq2.size(), n);
  endtask

  function automatic logic [31:0] got(input int i);
    if (i < oq2.size()) return {24'h0, oq2[i]};
    return 'x;
  endfunction

  function automatic logic [31:0] got_last(input int i);
    if (i < lq2.size()) return {31'h0, lq2[i]};
    return 'x;
  endfunction

  // Forward ShiftRows reference from the row/column definition.
  function automatic logic [7:0] exp_fwd(input logic [7:0] base, input int k);
    int r;
    int c;
    r = k % 4;
    c = k / 4;
    return base + 8'(r + 4 * ((c + r) % 4));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    nvec = 0;
    nmis = 0;
    cyc  = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
`ifdef SHIFT_ROWS_INV_EN
    mode_inv = 1'b0;
`endif
    clear();
    for (int i = 0; i < 16; i++) begin
      tbl[i].din      = 8'(i);
      tbl[i].exp      = fwd_tab[i];
      tbl[i].exp_last = (i == 15);
    end

    // Reset state, with garbage on the inputs
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", in_ready2, 1'b0);
    chk("rst_out_valid", out_valid2, 1'b0);
    chk("rst_out_last", out_last2, 1'b0);
    chk("rst_out_data", out_data2, 8'h00);
    chk("rst_in_ready_nb1", in_ready1, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    clear();
    chk("in_ready_after_release", in_ready2, 1'b1);
    chk("in_ready_after_release_nb1", in_ready1, 1'b1);

    // Single block 00..0F through the table
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[i].din;
      step();
    end
    drain(16);
    chk("first_out_latency", (cq2.size() > 0) ? cq2[0] : -1, acc2_cyc + 1);
    for (int i = 0; i < 16; i++) begin
      chk("tbl_data", got(i), {24'h0, tbl[i].exp});
      chk("tbl_last", got_last(i), {31'h0, tbl[i].exp_last});
    end

    // Two back-to-back blocks at full rate
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h20 + 8'(i);
      step();
    end
    chk("stream_accepted", acc2, 32);
    drain(32);
    for (int i = 0; i < 32; i++) begin
      chk("stream_data", got(i), {24'h0, exp_fwd(8'h20 + 8'(16 * (i / 16)), i % 16)});
      if (i > 0 && i < cq2.size()) chk("stream_gapless", cq2[i] - cq2[i-1], 1);
    end

    // Output stalled for 40 cycles: both buffers fill, then the input stalls
    do_reset();
    out_ready = 1'b0;
    hold_bad = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      if (out_valid2 && ((out_data2 !== 8'h00) || (out_last2 !== 1'b0))) hold_bad++;
      step();
    end
    chk("stall_accepted", acc2, 32);
    chk("stall_in_ready", in_ready2, 1'b0);
    chk("stall_out_valid", out_valid2, 1'b1);
    chk("stall_out_data", out_data2, 8'h00);
    chk("stall_hold", hold_bad, 0);
    out_ready = 1'b1;
    drain(32);
    for (int i = 0; i < 32; i++) begin
      chk("stall_drain_data", got(i), {24'h0, exp_fwd(8'(16 * (i / 16)), i % 16)});
    end

    // Reset in the middle of a block discards it
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("midrst_out_valid", out_valid2, 1'b0);
    chk("midrst_in_ready", in_ready2, 1'b0);
    rst_n = 1'b1;
    step();
    clear();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      step();
    end
    drain(16);
    for (int i = 0; i < 5; i++) step();
    chk("midrst_no_extra", oq2.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("midrst_data", got(i), {24'h0, exp_fwd(8'h10, i)});
    end

    // Single buffer: in_ready low from the 16th accept until after the last handshake
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h50 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 24; i++) step();
    chk("nb1_accepted", acc1, 16);
    low_cnt = 0;
    for (int c = acc1_16 + 1; c <= acc1_16 + 16; c++) begin
      if (c >= 0 && c < 4096 && rdy1_hist[c] === 1'b0) low_cnt++;
    end
    chk("nb1_ready_low_window", low_cnt, 16);
    chk("nb1_ready_back",
        (acc1_16 + 17 >= 0 && acc1_16 + 17 < 4096) ? {31'h0, rdy1_hist[acc1_16 + 17]} : 'x, 1);
    chk("nb1_last_cycle", l1_cyc, acc1_16 + 16);

`ifdef SHIFT_ROWS_INV_EN
    // Inverse block followed by a forward block; direction latched with byte 0 only
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i % 16);
      mode_inv = (i == 0) ? 1'b1 : ((i == 16) ? 1'b0 : (i < 16) ? 1'b0 : 1'b1);
      step();
    end
    mode_inv = 1'b0;
    drain(32);
    for (int i = 0; i < 16; i++) begin
      chk("inv_data", got(i), {24'h0, inv_tab[i]});
      chk("inv_then_fwd_data", got(i + 16), {24'h0, fwd_tab[i]});
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/shift_rows_stream.md
SHIFT_ROWS_STREAM -- requirements
Module: shift_rows_stream

Interface
REQ-001 SHALL have parameter NUM_BUF, default 2, number of 16-byte block buffers; only 1 or 2 are legal.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  input byte valid.
REQ-005 SHALL have port in_ready  output  1  block accepts an input byte.
REQ-006 SHALL have port in_data  input  8  input state byte, column-major order: byte i = row (i mod 4), column (i div 4); byte 0 = s(0,0).
REQ-007 SHALL have port out_valid  output  1  output byte valid.
REQ-008 SHALL have port out_ready  input  1  downstream accepts an output byte.
REQ-009 SHALL have port out_data  output  8  shifted state byte, same column-major order.
REQ-010 SHALL have port out_last  output  1  high with output byte 15 of each block.

Function
REQ-011 SHALL transfer a byte on either side only in a cycle where valid and ready are both high at the clock edge.
REQ-012 SHALL store input bytes in the current write buffer at write index 0..15; acceptance of index 15 marks the buffer full, moves to the next buffer (mod NUM_BUF) and resets the index to 0.
REQ-013 SHALL emit a full buffer at output index k = r + 4c (k 0..15) as buffered byte r + 4*((c + r) mod 4) (forward AES ShiftRows).
REQ-014 SHALL assert out_valid in the cycle after the 16th byte of a block is accepted, keeping it asserted until that block's index-15 handshake.
REQ-015 SHALL hold out_data and out_last stable while out_valid is high and out_ready is low.
REQ-016 SHALL release a buffer on its index-15 output handshake; the freed buffer is visible to in_ready from the next cycle, never in the same cycle.
REQ-017 SHALL drive in_ready from registered state only: high iff the current write buffer is not full; no combinational path from out_ready or in_valid to in_ready.
REQ-018 SHALL emit blocks strictly in arrival order; with NUM_BUF=2 and out_ready held high, sustain 1 byte/cycle on both sides indefinitely.
REQ-019 SHALL ignore in_data while in_valid is low; partial blocks remain buffered indefinitely with no timeout.

Reset
REQ-020 SHALL, while rst_n is low, force in_ready=0, out_valid=0, out_last=0, out_data=0x00, all write/read indices to 0 and all buffers to empty.
REQ-021 SHALL, on rst_n assertion mid-block, discard all partial and full blocks; the first byte accepted after release is byte 0 of a new block.
REQ-022 SHALL assert in_ready in the first cycle after rst_n deasserts.

Configuration
REQ-023 SHALL, when SHIFT_ROWS_INV_EN is defined, add input port mode_inv (1 bit), sampled with byte 0 of each block and stored per buffer; mode_inv=1 emits index k = r + 4c as buffered byte r + 4*((c - r) mod 4) (InvShiftRows).
REQ-024 SHALL, when SHIFT_ROWS_INV_EN is undefined, omit port mode_inv and implement forward ShiftRows only.

Structure
REQ-025 SHALL take AES_NB=4, AES_BLOCK_BYTES=16 and the forward/inverse byte-index functions from shared package aes_pkg.
REQ-026 SHALL implement each buffer as sub-module sr_block_buf, instantiated NUM_BUF times: 16x8 storage, full flag, stored mode bit; top level holds indices, buffer selection and the output mux.

Verification
REQ-027 SHALL cover: bytes 00..0F, out_ready=1 -> out 00,05,0A,0F,04,09,0E,03,08,0D,02,07,0C,01,06,0B; out_last only on 0B; first out_valid one cycle after 0F is accepted.
REQ-028 SHALL cover: NUM_BUF=2, 32 consecutive bytes, out_ready=1 -> in_ready never drops; 32 output bytes on consecutive cycles in order.
REQ-029 SHALL cover: out_ready=0 for 40 cycles, in_valid=1 -> exactly 32 bytes accepted, then in_ready=0; out_valid=1 with out_data held at 00.
REQ-030 SHALL cover: rst_n pulsed low after 7 bytes accepted -> out_valid=0; a following block 10..1F emits 10,15,1A,1F,... with no stale data.
REQ-031 SHALL cover: SHIFT_ROWS_INV_EN defined, mode_inv=1, bytes 00..0F -> out 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03.
REQ-032 SHALL cover: NUM_BUF=1, out_ready=1 -> in_ready low from the 16th input acceptance until one cycle after the out_last handshake.
